pri_encoder_rr: RTL

Parametrised, registered successor to the 16-bit combinational priority encoder. It captures one-cycle request pulses into a sticky pending register. It then issues one encoded index per handshake, with a selectable fixed (LSB-first) or round-robin priority. It sits between a bank of request sources (interrupt lines, channel-ready flags) and a single consumer that services one index at a time.

---
 rtl/pri_encoder_rr.sv | 114 +++++++++++
 1 files changed

// File: rtl/pri_encoder_rr.sv
// pri_encoder_rr
// ----------------------------------------------------------------------------
// Registered priority encoder with sticky request capture and a valid/ready
// output handshake. One-cycle request pulses are OR-ed into a pending
// register. Each handshake issues one encoded index. Priority is either fixed
// (index 0 highest) or round-robin (search starts just after the last grant).
//
// Parameters:
//   WIDTH    number of request lines (>= 2, any value, not only powers of two)
//   OUT_W    encoded index width, derived from WIDTH (do not override)
//   RR_MODE  0 = fixed LSB-first priority, 1 = round-robin priority
//
// Ports:
//   clk          rising-edge clock
//   reset        synchronous, active-high reset
//   enable       low blocks request capture and blocks new output loads
//   encoder_in   request pulses, OR-ed into the pending register
//   ready_in     consumer accepts binary_out when valid_out && ready_in
//   binary_out   encoded index of the issued request
//   valid_out    binary_out holds an issued, not yet accepted index
//   pending_out  current pending register
// ----------------------------------------------------------------------------
module pri_encoder_rr #(
    parameter int WIDTH   = 16,
    parameter int OUT_W   = $clog2(WIDTH),
    parameter bit RR_MODE = 1'b0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable,
    input  logic [WIDTH-1:0] encoder_in,
    input  logic             ready_in,
    output logic [OUT_W-1:0] binary_out,
    output logic             valid_out,
    output logic [WIDTH-1:0] pending_out
);

    logic [WIDTH-1:0] pending;
    logic [OUT_W-1:0] ptr;

    logic [OUT_W-1:0] sel;
    logic             found;
    logic             load;
    logic [WIDTH-1:0] clr;
    logic [OUT_W-1:0] ptr_next;

    // Selection looks only at the registered pending bits, never at
    // encoder_in, so there is no input-to-output combinational path.
    // The search runs over offsets from the start point and wraps at WIDTH,
    // which keeps non-power-of-two widths correct.
    always_comb begin
        int idx;
        // NOTE: every variable written here gets a default first, so no path
        // through the block leaves it unassigned and no latch is inferred.
        sel   = '0;
        found = 1'b0;
        idx   = 0;
        for (int i = 0; i < WIDTH; i++) begin
            idx = (RR_MODE ? int'(ptr) : 0) + i;
            if (idx >= WIDTH) begin
                idx = idx - WIDTH;
            end
            if (!found && pending[OUT_W'(idx)]) begin
                found = 1'b1;
                sel   = OUT_W'(idx);
            end
        end
    end

    // A new index may enter the slot when the slot is empty or is being
    // accepted on this same edge; this gives back-to-back issue.
    assign load = enable && (!valid_out || ready_in);

    assign clr = (load && found) ? (WIDTH'(1) << sel) : '0;

    assign ptr_next = (sel == OUT_W'(WIDTH - 1)) ? '0 : sel + OUT_W'(1);

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk) begin
        if (reset) begin
            pending    <= '0;
            valid_out  <= 1'b0;
            binary_out <= '0;
            ptr        <= '0;
        end else begin
            // Clear is applied before the OR, so a request arriving on the
            // edge its bit is granted stays pending (set beats clear).
            if (enable) begin
                pending <= (pending & ~clr) | encoder_in;
            end

            if (load) begin
                if (found) begin
                    binary_out <= sel;
                    valid_out  <= 1'b1;
                    if (RR_MODE) begin
                        ptr <= ptr_next;
                    end
                end else begin
                    // Nothing to issue: drop valid, keep last index visible.
                    valid_out <= 1'b0;
                end
            end else if (valid_out && ready_in) begin
                // enable=0: the pending handshake still completes, but no
                // new index is loaded behind it.
                valid_out <= 1'b0;
            end
        end
    end

    assign pending_out = pending;

endmodule
